// File: rtl/cop0_regfile.sv
// MIPS coprocessor-0 subset: BadVAddr, Count, Compare, Status, Cause, EPC.
// Reads are combinational with no write bypass; exception > eret > MTC0.
module cop0_regfile #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        eret,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_bva_valid,
  input  logic [5:0]  hw_int,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        int_pending
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [31:0]   count_q;
  logic [31:0]   compare_q;
  logic [31:0]   badvaddr_q;
  logic [31:0]   epc_q;
  logic [7:0]    im_q;
  logic          exl_q;
  logic          ie_q;
  logic          bd_q;
  logic          ti_q;
  logic [1:0]    ip_sw_q;
  logic [4:0]    exccode_q;

  logic        mtc0;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        div_wrap;
  logic        count_inc;
  logic [31:0] count_next;
  logic [7:0]  ip;

  // MTC0 only lands when no exception or eret commits in the same cycle.
  assign mtc0       = we & ~exc_valid & ~eret & (wsel == 3'd0);
  assign wr_count   = mtc0 & (waddr == 5'd9);
  assign wr_compare = mtc0 & (waddr == 5'd11);
  assign wr_status  = mtc0 & (waddr == 5'd12);
  assign wr_cause   = mtc0 & (waddr == 5'd13);
  assign wr_epc     = mtc0 & (waddr == 5'd14);

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign count_inc  = div_wrap & ~wr_count;
  assign count_next = count_q + 32'd1;

  assign ip = {hw_int[5] | ti_q, hw_int[4:0], ip_sw_q};

  assign status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause  = {bd_q, ti_q, 14'd0, ip, 1'b0, exccode_q, 2'b00};
  assign epc    = epc_q;

  assign int_pending = ie_q & ~exl_q & (|(ip & im_q));

  always_comb begin
    rdata = 32'd0;
    if (rsel == 3'd0) begin
      case (raddr)
        5'd8:    rdata = badvaddr_q;
        5'd9:    rdata = count_q;
        5'd11:   rdata = compare_q;
        5'd12:   rdata = status;
        5'd13:   rdata = cause;
        5'd14:   rdata = epc_q;
        default: rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      badvaddr_q <= 32'd0;
      epc_q      <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      exccode_q  <= 5'd0;
    end else begin
      if (wr_count) begin
        count_q <= wdata;
        div_cnt <= '0;
      end else if (div_wrap) begin
        count_q <= count_next;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // A Compare write clears TI even if an increment would match this cycle.
      if (wr_compare) begin
        compare_q <= wdata;
        ti_q      <= 1'b0;
      end else if (count_inc && (count_next == compare_q)) begin
        ti_q <= 1'b1;
      end

      if (exc_valid) begin
        if (!exl_q) begin
          epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          bd_q  <= exc_bd;
        end
        exccode_q <= exc_code;
        exl_q     <= 1'b1;
        if (exc_bva_valid) badvaddr_q <= exc_badvaddr;
      end else if (eret) begin
        exl_q <= 1'b0;
      end else begin
        if (wr_status) begin
          im_q  <= wdata[15:8];
          exl_q <= wdata[1];
          ie_q  <= wdata[0];
        end
        if (wr_cause) ip_sw_q <= wdata[9:8];
        if (wr_epc)   epc_q   <= wdata;
      end
    end
  end

endmodule
